// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared definitions for the AES key-schedule controller slice.
//   KEY_LEN         : cipher key / round key width in bits
//   NUMS_OF_ROUND   : number of expanded round keys (rounds 1..NUMS_OF_ROUND)
//   RK_IDX_W        : width of the round-key index on the lookup port
//   CNT_W           : width of the expansion timeout counter
//   TIMEOUT_CYC_DEF : default timeout budget in EXPAND cycles
//   state_t         : controller state encoding
package aes_pkg;

    localparam int KEY_LEN         = 128;
    localparam int NUMS_OF_ROUND   = 10;
    localparam int RK_IDX_W        = 4;
    localparam int CNT_W           = 8;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef logic [KEY_LEN-1:0]  key_t;
    typedef logic [RK_IDX_W-1:0] rk_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Host-side bus of the key-schedule controller.
//   key_in/key_valid/key_ready : cipher key offer with valid/ready handshake
//   rk_req/rk_idx              : round-key lookup request from the round engine
//   rk_valid/rk_key/rk_err     : registered lookup response, one cycle later
// master = key host / round engine side, slave = controller side.
interface aes_key_sched_ctrl_if;
    import aes_pkg::*;

    key_t    key_in;
    logic    key_valid;
    logic    key_ready;
    logic    rk_req;
    rk_idx_t rk_idx;
    logic    rk_valid;
    key_t    rk_key;
    logic    rk_err;

    modport master (
        output key_in, key_valid, rk_req, rk_idx,
        input  key_ready, rk_valid, rk_key, rk_err
    );

    modport slave (
        input  key_in, key_valid, rk_req, rk_idx,
        output key_ready, rk_valid, rk_key, rk_err
    );

endinterface

// File: rtl/aes_rk_select.sv
// Registered round-key lookup port.
//   clk, reset      : clock, asynchronous active-low reset
//   keys_ok         : controller is in READY this cycle
//   rk_req, rk_idx  : lookup request and round index (0..NUMS_OF_ROUND)
//   base_key        : round-0 key (the cipher key currently driven to KeyExpantion)
//   key_expan       : expanded keys, slice i holds the key for round i+1
//   rk_valid        : one-cycle response strobe, one cycle after rk_req
//   rk_key          : selected round key, zero on a rejected request
//   rk_err          : response is a rejection (bad index or keys not ready)
module aes_rk_select
    import aes_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             keys_ok,
    input  logic                             rk_req,
    input  rk_idx_t                          rk_idx,
    input  key_t                             base_key,
    input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] key_expan,
    output logic                             rk_valid,
    output key_t                             rk_key,
    output logic                             rk_err
);

    logic rk_valid_d, rk_valid_q;
    key_t rk_key_d,   rk_key_q;
    logic rk_err_d,   rk_err_q;
    key_t sel_key;
    logic idx_ok;

    always_comb begin
        sel_key = base_key;
        for (int i = 1; i <= NUMS_OF_ROUND; i++) begin
            if (rk_idx == RK_IDX_W'(i)) begin
                sel_key = key_expan[(i-1)*KEY_LEN +: KEY_LEN];
            end
        end
        idx_ok = (rk_idx <= RK_IDX_W'(NUMS_OF_ROUND));

        rk_valid_d = rk_req;
        rk_err_d   = 1'b0;
        rk_key_d   = rk_key_q;       // key holds between requests
        if (rk_req) begin
            if (keys_ok && idx_ok) begin
                rk_key_d = sel_key;
            end else begin
                rk_err_d = 1'b1;
                rk_key_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rk_valid_q <= 1'b0;
            rk_key_q   <= '0;
            rk_err_q   <= 1'b0;
        end else begin
            rk_valid_q <= rk_valid_d;
            rk_key_q   <= rk_key_d;
            rk_err_q   <= rk_err_d;
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_key   = rk_key_q;
    assign rk_err   = rk_err_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequencing controller between the key host and the KeyExpantion datapath.
// Accepts a cipher key, holds it on kx_key with kx_valid_in asserted until all
// round keys are valid, then serves round keys through a registered lookup port.
//   clk, reset   : clock, asynchronous active-low reset
//   bus (slave)  : key handshake and round-key lookup port
//   keys_ready   : all round keys valid and stable
//   busy         : expansion in progress
//   err_timeout  : sticky, last expansion ran out of time
//   kx_key       : key driven to KeyExpantion (registered)
//   kx_valid_in  : valid to KeyExpantion
//   kx_key_expan : expanded keys from KeyExpantion
//   kx_valid_out : per-round valid flags from KeyExpantion
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    aes_key_sched_ctrl_if.slave              bus,
    output logic                             keys_ready,
    output logic                             busy,
    output logic                             err_timeout,
    output key_t                             kx_key,
    output logic                             kx_valid_in,
    input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] kx_key_expan,
    input  logic [NUMS_OF_ROUND-1:0]         kx_valid_out
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

    state_t           state_d,       state_q;
    logic [CNT_W-1:0] cnt_d,         cnt_q;
    key_t             kx_key_d,      kx_key_q;
    logic             kx_valid_in_d, kx_valid_in_q;
    logic             key_ready_d,   key_ready_q;
    logic             keys_ready_d,  keys_ready_q;
    logic             busy_d,        busy_q;
    logic             err_timeout_d, err_timeout_q;

    logic accept;
    logic all_valid;

    assign accept    = bus.key_valid & key_ready_q;
    assign all_valid = &kx_valid_out;

    // NOTE: every signal gets a hold value before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kx_key_d      = kx_key_q;
        err_timeout_d = err_timeout_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (accept) state_d = ST_EXPAND;
            end
            ST_READY: begin
                // A lost valid_out bit means the keys can no longer be trusted:
                // re-enter EXPAND with the same key and a fresh timeout budget.
                if (accept || !all_valid) begin
                    state_d = ST_EXPAND;
                    cnt_d   = '0;
                end
            end
            ST_EXPAND: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (all_valid) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == TIMEOUT_LIM) begin
                        state_d       = ST_ERROR;
                        err_timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            kx_key_d      = bus.key_in;
            cnt_d         = '0;
            err_timeout_d = 1'b0;
        end

        // Status outputs are decoded from the next state and registered.
        key_ready_d   = (state_d != ST_EXPAND);
        busy_d        = (state_d == ST_EXPAND);
        keys_ready_d  = (state_d == ST_READY);
        kx_valid_in_d = (state_d == ST_EXPAND) || (state_d == ST_READY);
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            kx_key_q      <= '0;
            kx_valid_in_q <= 1'b0;
            key_ready_q   <= 1'b1;
            keys_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kx_key_q      <= kx_key_d;
            kx_valid_in_q <= kx_valid_in_d;
            key_ready_q   <= key_ready_d;
            keys_ready_q  <= keys_ready_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Lookups use the pre-edge state and key, so a request arriving with a new
    // key accept is still served from the old key.
    aes_rk_select u_rk_select (
        .clk       (clk),
        .reset     (reset),
        .keys_ok   (state_q == ST_READY),
        .rk_req    (bus.rk_req),
        .rk_idx    (bus.rk_idx),
        .base_key  (kx_key_q),
        .key_expan (kx_key_expan),
        .rk_valid  (bus.rk_valid),
        .rk_key    (bus.rk_key),
        .rk_err    (bus.rk_err)
    );

    assign bus.key_ready = key_ready_q;
    assign keys_ready    = keys_ready_q;
    assign busy          = busy_q;
    assign err_timeout   = err_timeout_q;
    assign kx_key        = kx_key_q;
    assign kx_valid_in   = kx_valid_in_q;

endmodule
